// File: rtl/inst_fetch_mem_if.sv
// Fetch request/response, program-load and status signals shared by the fetch memory and its requester.
interface inst_fetch_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_fault;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic        busy;

    modport master (
        output req_valid, req_addr, resp_ready, load_en, load_addr, load_data,
        input  req_ready, resp_valid, resp_data, resp_fault, busy
    );

    modport slave (
        input  req_valid, req_addr, resp_ready, load_en, load_addr, load_data,
        output req_ready, resp_valid, resp_data, resp_fault, busy
    );
endinterface

// File: rtl/inst_fetch_mem.sv
// Instruction fetch memory: word array read on acceptance, result carried through a LATENCY-stage pipe.
// A stalled response freezes every stage and drops req_ready; program loads also drop req_ready.
module inst_fetch_mem #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    inst_fetch_mem_if.slave  bus
);

    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);

    if (LATENCY == 0 || LATENCY > 4) begin : g_bad_latency
        $error("inst_fetch_mem: LATENCY must be within 1..4");
    end
    if (DEPTH_WORDS < 16 || DEPTH_WORDS > 65536 ||
        (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("inst_fetch_mem: DEPTH_WORDS must be a power of two within 16..65536");
    end
    if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
        $error("inst_fetch_mem: BASE_ADDR must be word aligned");
    end

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]      req_off;
    logic [31:0]      load_off;
    logic             req_fault;
    logic             load_ok;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] load_idx;

    // The 32-bit subtraction wraps for addresses below BASE_ADDR, so the
    // explicit lower-bound compare keeps those from aliasing into the array.
    assign req_off   = bus.req_addr - BASE_ADDR;
    assign load_off  = bus.load_addr - BASE_ADDR;
    assign req_fault = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr < BASE_ADDR) ||
                       (req_off >= SPAN_BYTES);
    assign load_ok   = bus.load_en && (bus.load_addr[1:0] == 2'b00) &&
                       (bus.load_addr >= BASE_ADDR) && (load_off < SPAN_BYTES);
    assign req_idx   = req_off[IDX_W+1:2];
    assign load_idx  = load_off[IDX_W+1:2];

    logic [LATENCY-1:0] stg_vld;
    logic [LATENCY-1:0] stg_flt;
    logic [31:0]        stg_dat [LATENCY];
    logic               stall;
    logic               accept;

    assign stall         = stg_vld[LATENCY-1] && !bus.resp_ready;
    assign bus.req_ready = rst && !bus.load_en && !stall;
    assign accept        = bus.req_valid && bus.req_ready;

    // Memory has no reset so a loaded program survives rst.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[load_idx] <= bus.load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stg_vld <= '0;
            stg_flt <= '0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                stg_dat[i] <= '0;
            end
        end else if (!stall) begin
            stg_vld[0] <= accept;
            stg_flt[0] <= accept && req_fault;
            stg_dat[0] <= (accept && !req_fault) ? mem[req_idx] : 32'h0000_0000;
            for (int i = 1; i < int'(LATENCY); i++) begin
                stg_vld[i] <= stg_vld[i-1];
                stg_flt[i] <= stg_flt[i-1];
                stg_dat[i] <= stg_dat[i-1];
            end
        end
    end

    assign bus.resp_valid = stg_vld[LATENCY-1];
    assign bus.resp_fault = stg_flt[LATENCY-1];
    assign bus.resp_data  = stg_dat[LATENCY-1];
    assign bus.busy       = |stg_vld;

endmodule
